// File: rtl/issue_port_arbiter.sv
// Round-robin arbiter sharing N_PORT credit-limited issue ports between N_REQ issue queues.
// Optional starvation override enabled by defining ISSUE_ARB_STARVE_EN.
module issue_port_arbiter #(
  parameter int N_REQ        = 4,
  parameter int N_PORT       = 2,
  parameter int CREDITS      = 4,
  parameter int ROB_W        = 8,
  parameter int DEST_W       = 7,
  parameter int STARVE_LIMIT = 8,
  localparam int SRC_W       = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*ROB_W-1:0]     req_rob_idx_i,
  input  logic [N_REQ*DEST_W-1:0]    req_dest_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [N_PORT-1:0]          port_valid_o,
  output logic [N_PORT*ROB_W-1:0]    port_rob_idx_o,
  output logic [N_PORT*DEST_W-1:0]   port_dest_o,
  output logic [N_PORT*SRC_W-1:0]    port_src_o,
  input  logic [N_PORT-1:0]          port_done_i,
  input  logic                       flush_i,
  output logic                       err_o
);
  localparam int CRED_W = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  logic [CRED_W-1:0] r_credit     [N_PORT];
  logic              r_port_valid [N_PORT];
  logic [ROB_W-1:0]  r_port_rob   [N_PORT];
  logic [DEST_W-1:0] r_port_dest  [N_PORT];
  logic [SRC_W-1:0]  r_port_src   [N_PORT];
  logic [SRC_W-1:0]  r_rr_ptr;
  logic              r_err;

  logic [SRC_W-1:0]  w_order    [N_REQ];
  logic [SRC_W-1:0]  w_port_src [N_PORT];
  logic [N_REQ-1:0]  w_ready;
  logic [N_REQ-1:0]  w_grant;
  logic [N_PORT-1:0] w_issue;
  logic [N_PORT-1:0] w_ovf;
  logic [SRC_W-1:0]  w_last;
  logic              w_any;
  logic              w_found;

`ifdef ISSUE_ARB_STARVE_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] r_wait [N_REQ];
  logic [N_REQ-1:0]  w_starve;
  logic [SRC_W-1:0]  w_idx;
  int                w_n;

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_starve
    assign w_starve[gi] = (r_wait[gi] >= WAIT_MAX);
  end

  // Starving requesters go first in index order, then the rest in rr order.
  always_comb begin
    w_n   = 0;
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) w_order[i] = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_starve[i]) begin
        w_order[w_n] = SRC_W'(i);
        w_n = w_n + 1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = r_rr_ptr + SRC_W'(i);
      if (!w_starve[w_idx]) begin
        w_order[w_n] = w_idx;
        w_n = w_n + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst || flush_i || !req_valid_i[i] || w_grant[i]) begin
        r_wait[i] <= '0;
      end else if (r_wait[i] != WAIT_MAX) begin
        r_wait[i] <= r_wait[i] + 1'b1;
      end
    end
  end
`else
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_order
    assign w_order[gi] = r_rr_ptr + SRC_W'(gi);
  end
`endif

  // Each requester in scan order is offered the lowest free port with credit,
  // whether or not it is valid; only a valid requester consumes that port.
  always_comb begin
    w_ready = '0;
    w_grant = '0;
    w_issue = '0;
    w_last  = '0;
    w_any   = 1'b0;
    w_found = 1'b0;
    for (int p = 0; p < N_PORT; p++) w_port_src[p] = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_found = 1'b0;
      for (int p = 0; p < N_PORT; p++) begin
        if (!w_found && !w_issue[p] && (r_credit[p] != '0)) begin
          w_found = 1'b1;
          if (!rst && !flush_i) begin
            w_ready[w_order[i]] = 1'b1;
            if (req_valid_i[w_order[i]]) begin
              w_grant[w_order[i]] = 1'b1;
              w_issue[p]          = 1'b1;
              w_port_src[p]       = w_order[i];
              w_last              = w_order[i];
              w_any               = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
      for (int p = 0; p < N_PORT; p++) begin
        r_credit[p]     <= CRED_MAX;
        r_port_valid[p] <= 1'b0;
        r_port_rob[p]   <= '0;
        r_port_dest[p]  <= '0;
        r_port_src[p]   <= '0;
      end
    end else if (flush_i) begin
      r_rr_ptr <= '0;
      for (int p = 0; p < N_PORT; p++) begin
        r_credit[p]     <= CRED_MAX;
        r_port_valid[p] <= 1'b0;
      end
    end else begin
      if (w_any) r_rr_ptr <= w_last + 1'b1;
      if (|w_ovf) r_err <= 1'b1;
      for (int p = 0; p < N_PORT; p++) begin
        r_port_valid[p] <= w_issue[p];
        if (w_issue[p]) begin
          r_port_rob[p]  <= req_rob_idx_i[w_port_src[p]*ROB_W +: ROB_W];
          r_port_dest[p] <= req_dest_i[w_port_src[p]*DEST_W +: DEST_W];
          r_port_src[p]  <= w_port_src[p];
        end
        if (w_issue[p] && !port_done_i[p]) begin
          r_credit[p] <= r_credit[p] - 1'b1;
        end else if (!w_issue[p] && port_done_i[p] && (r_credit[p] != CRED_MAX)) begin
          r_credit[p] <= r_credit[p] + 1'b1;
        end
      end
    end
  end

  genvar gp;
  for (gp = 0; gp < N_PORT; gp++) begin : g_port
    assign w_ovf[gp] = port_done_i[gp] && !w_issue[gp] && (r_credit[gp] == CRED_MAX);
    assign port_valid_o[gp]                    = r_port_valid[gp];
    assign port_rob_idx_o[gp*ROB_W +: ROB_W]   = r_port_rob[gp];
    assign port_dest_o[gp*DEST_W +: DEST_W]    = r_port_dest[gp];
    assign port_src_o[gp*SRC_W +: SRC_W]       = r_port_src[gp];
  end

  assign req_ready_o = w_ready;
  assign err_o       = r_err;
endmodule

// File: doc/issue_port_arbiter.md
Name: issue_port_arbiter

Overview:
Shares N_PORT execution issue ports between N_REQ issue-queue requesters. Each requester offers one ready micro-op per cycle.
- Arbitration is round-robin, with a per-port credit counter that bounds in-flight ops.
- Winners are registered onto the port outputs.
- Sits between the issue queues and the execution units; credits return via per-port completion pulses.

Parameters:
N_REQ, 4, number of requesting issue queues (≥2, power of 2)
N_PORT, 2, number of shared execution ports (1..N_REQ)
CREDITS, 4, max in-flight ops per port
ROB_W, 8, ROB index width
DEST_W, 7, physical destination tag width
STARVE_LIMIT, 8, starvation threshold in cycles (used only with ISSUE_ARB_STARVE_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid_i  in  N_REQ  requester r offers an op
req_rob_idx_i  in  N_REQ x ROB_W  ROB index per requester
req_dest_i  in  N_REQ x DEST_W  destination tag per requester
req_ready_o  out  N_REQ  grant; transfer occurs when valid && ready
port_valid_o  out  N_PORT  op issued on port p (registered)
port_rob_idx_o  out  N_PORT x ROB_W  issued ROB index
port_dest_o  out  N_PORT x DEST_W  issued destination tag
port_src_o  out  N_PORT x clog2(N_REQ)  winning requester id
port_done_i  in  N_PORT  one-cycle pulse: one op on port p completed, returns one credit
flush_i  in  1  pipeline flush
err_o  out  1  sticky credit-overflow error

Behaviour:
- Reset (rst=1 at posedge): port_valid_o=0, payload outputs=0, port_src_o=0, credits=CREDITS, rr_ptr=0, err_o=0. req_ready_o=0 while rst is high.
- Grant is combinational in the same cycle:
  - Scan requesters circularly starting at rr_ptr.
  - Each requester with valid=1 is assigned the lowest-numbered unassigned port whose credit>0.
  - At most N_PORT grants per cycle, at most one per requester.
  - req_ready_o never depends on req_valid_i of the same requester (no combinational loop through ready).
- Issue latency: 1 cycle. A transfer in cycle t gives port_valid_o[p]=1 with its payload in cycle t+1. Ports with no grant drive port_valid_o=0; payload holds its last value.
- rr_ptr update: after any cycle with ≥1 grant, rr_ptr <= (highest-priority-order last granted requester + 1) mod N_REQ. Otherwise unchanged.
- Credits, per port, width clog2(CREDITS+1):
  - Issue only: -1.
  - done only: +1.
  - Issue and done in the same cycle: unchanged.
  - credit==0: port is not eligible for grants.
  - done at credit==CREDITS with no issue: ignored, counter saturates, err_o set (sticky until rst).
- Flush:
  - flush_i=1 suppresses all grants that cycle (req_ready_o=0).
  - Next cycle: port_valid_o=0, all credits=CREDITS, rr_ptr=0.
  - port_done_i is ignored in the flush cycle.
- Zero requests: no grants, state unchanged except credit returns.
- Reset mid-operation: rst overrides flush and done; in-flight outputs are dropped at the next edge.

Optional Feature:
ISSUE_ARB_STARVE_EN:
- Defined:
  - Each requester has a wait counter, clog2(STARVE_LIMIT+1) wide. It increments when valid && !ready, and clears on grant or when valid=0.
  - When a requester's counter reaches STARVE_LIMIT, it is scanned first, ahead of rr_ptr order. Among multiple starving requesters, lowest index goes first.
  - Counters clear on rst and flush.
- Undefined: pure round-robin; no counters are synthesised.

Test Plan:
1. Reset, then all 4 requesters valid every cycle, done pulsed each cycle on both ports -> grants {0,1}, {2,3}, {0,1}...; port_src_o matches; port_valid_o=2'b11 one cycle after each grant.
2. Requester 2 only valid, no done pulses -> issued on port 0 in 4 consecutive cycles, then on port 1 in 4 cycles; after 8 issues req_ready_o[2]=0 with both credits 0. One port_done_i[0] pulse -> next grant goes to port 0.
3. Simultaneous issue and done on port 0 with credit=1 -> credit stays 1, port 0 still eligible next cycle.
4. flush_i asserted while 2 ops granted in the same cycle -> req_ready_o=0 that cycle; next cycle port_valid_o=0, credits=4/4, rr_ptr=0.
5. port_done_i[1] with port 1 credit=4 and no issue -> credit stays 4, err_o=1 and remains 1 until rst.
6. (ISSUE_ARB_STARVE_EN, N_PORT=1, STARVE_LIMIT=3) requester 3 held off by a priority pattern for 3 cycles -> granted in 4th cycle regardless of rr_ptr.
